// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcodes, datapath select codes.
// JAL_SUPPORT_EN adds the JAL state; without it, jal decodes to HALT.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
`ifdef JAL_SUPPORT_EN
    S_JAL    = 4'd12,
`endif
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_SUPPORT_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // DECODE dispatch; any unrecognised opcode stops the machine.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXEC;
      OP_LW, OP_SW: return S_MEMADR;
      OP_BEQ:       return S_BRANCH;
      OP_ADDI:      return S_ADDIEX;
      OP_J:         return S_JUMP;
`ifdef JAL_SUPPORT_EN
      OP_JAL:       return S_JAL;
`endif
      default:      return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running count of retired instructions; wraps at 2^32, cleared asynchronously by reset_n.
module retire_counter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [31:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count <= 32'd0;
    else if (enable) count <= count + 32'd1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM with datapath selects and a retired-instruction count.
// Define JAL_SUPPORT_EN to enable the JAL state (writes PC+4 to r31 and jumps).
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] retired
);

  state_t state_q, state_d;
  logic   retire_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(opcode);
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
`ifdef JAL_SUPPORT_EN
      S_JAL:    state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are gated by reset_n so they read zero during reset without waiting for a clock.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    halted     = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM;
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = zero;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
`ifdef JAL_SUPPORT_EN
        S_JAL: begin
          reg_write = 1'b1;
          pc_src    = PCSRC_JUMP;
          pc_write  = 1'b1;
        end
`endif
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign state     = state_q;
  assign retire_en = (state_q != S_FETCH) && (state_d == S_FETCH);

  retire_counter u_retire_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (retire_en),
    .count   (retired)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; covers both JAL_SUPPORT_EN builds.
module tb_multicycle_ctrl;

  localparam int W = 52;  // {retired[31:0], state[3:0], halted, ctl[14:0]}

  // ctl = {mem_req, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
  //        mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]}
  localparam logic [14:0] C_ZERO   = 15'b0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_FWAIT  = 15'b1_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] C_FRDY   = 15'b1_0_0_1_1_0_0_0_0_01_00_00;
  localparam logic [14:0] C_DECODE = 15'b0_0_0_0_0_0_0_0_0_10_00_00;
  localparam logic [14:0] C_ADR    = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] C_MEMRD  = 15'b1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] C_MEMWR  = 15'b1_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [14:0] C_BR1    = 15'b0_0_0_0_1_0_0_0_1_00_01_01;
  localparam logic [14:0] C_BR0    = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] C_ADDIWB = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [14:0] C_JUMP   = 15'b0_0_0_0_1_0_0_0_0_00_00_10;
  localparam logic [14:0] C_JAL    = 15'b0_0_0_0_1_1_0_0_0_00_00_10;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, iord, ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, halted;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] retired;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           vec_id = 0;
  int           vectors = 0;
  int           miscompares = 0;

  // clock / reset block
  always #5 clock = ~clock;

  multicycle_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state),
    .halted     (halted),
    .retired    (retired)
  );

  // driver: apply one cycle of inputs just after the rising edge and queue the expected outputs
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] st, input logic h, input logic [14:0] c,
                      input logic [31:0] ret);
    reset_n   = r;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    exp_q.push_back({ret, st, h, c});
    id_q.push_back(vec_id);
    vec_id++;
    @(posedge clock);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      int id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {retired, state, halted, mem_req, mem_write, iord, ir_write, pc_write, reg_write,
            reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got ret=%0d st=%0d halted=%b ctl=%b, expected ret=%0d st=%0d halted=%b ctl=%b",
                 id, a[51:20], a[19:16], a[15], a[14:0], e[51:20], e[19:16], e[15], e[14:0]);
      end
    end
  end

  initial begin
    @(posedge clock);
    #1;
    // reset holds outputs low even with mem_ready high
    step(0, LW,  0, 1, 4'd0, 0, C_ZERO,   0);
    // lw with mem_ready always high: 0,1,2,3,4,0
    step(1, LW,  0, 1, 4'd0, 0, C_FRDY,   0);
    step(1, LW,  0, 1, 4'd1, 0, C_DECODE, 0);
    step(1, LW,  0, 1, 4'd2, 0, C_ADR,    0);
    step(1, LW,  0, 1, 4'd3, 0, C_MEMRD,  0);
    step(1, LW,  0, 1, 4'd4, 0, C_MEMWB,  0);
    // FETCH stalls three cycles, then beq taken
    for (int i = 0; i < 3; i++) step(1, BEQ, 0, 0, 4'd0, 0, C_FWAIT, 1);
    step(1, BEQ, 1, 1, 4'd0, 0, C_FRDY,   1);
    step(1, BEQ, 1, 1, 4'd1, 0, C_DECODE, 1);
    step(1, BEQ, 1, 1, 4'd8, 0, C_BR1,    1);
    // R-type
    step(1, RT,  0, 1, 4'd0, 0, C_FRDY,   2);
    step(1, RT,  0, 1, 4'd1, 0, C_DECODE, 2);
    step(1, RT,  0, 1, 4'd6, 0, C_EXEC,   2);
    step(1, RT,  0, 1, 4'd7, 0, C_ALUWB,  2);
    // beq not taken
    step(1, BEQ, 0, 1, 4'd0, 0, C_FRDY,   3);
    step(1, BEQ, 0, 1, 4'd1, 0, C_DECODE, 3);
    step(1, BEQ, 0, 1, 4'd8, 0, C_BR0,    3);
    // addi
    step(1, ADDI, 0, 1, 4'd0,  0, C_FRDY,   4);
    step(1, ADDI, 0, 1, 4'd1,  0, C_DECODE, 4);
    step(1, ADDI, 0, 1, 4'd9,  0, C_ADR,    4);
    step(1, ADDI, 0, 1, 4'd10, 0, C_ADDIWB, 4);
    // j
    step(1, JMP, 0, 1, 4'd0,  0, C_FRDY,   5);
    step(1, JMP, 0, 1, 4'd1,  0, C_DECODE, 5);
    step(1, JMP, 0, 1, 4'd11, 0, C_JUMP,   5);
    // sw with one wait cycle
    step(1, SW,  0, 1, 4'd0, 0, C_FRDY,   6);
    step(1, SW,  0, 1, 4'd1, 0, C_DECODE, 6);
    step(1, SW,  0, 1, 4'd2, 0, C_ADR,    6);
    step(1, SW,  0, 0, 4'd5, 0, C_MEMWR,  6);
    step(1, SW,  0, 1, 4'd5, 0, C_MEMWR,  6);
    // sw interrupted by reset mid-MEMWR
    step(1, SW,  0, 1, 4'd0, 0, C_FRDY,   7);
    step(1, SW,  0, 1, 4'd1, 0, C_DECODE, 7);
    step(1, SW,  0, 1, 4'd2, 0, C_ADR,    7);
    step(1, SW,  0, 0, 4'd5, 0, C_MEMWR,  7);
    step(0, SW,  0, 0, 4'd0, 0, C_ZERO,   0);
    step(0, SW,  0, 1, 4'd0, 0, C_ZERO,   0);
    // jal
    step(1, JAL, 0, 1, 4'd0, 0, C_FRDY,   0);
    step(1, JAL, 0, 1, 4'd1, 0, C_DECODE, 0);
`ifdef JAL_SUPPORT_EN
    step(1, JAL, 0, 1, 4'd12, 0, C_JAL,   0);
    step(1, BAD, 0, 1, 4'd0,  0, C_FRDY,  1);
    step(1, BAD, 0, 1, 4'd1,  0, C_DECODE, 1);
    for (int i = 0; i < 11; i++)
      step(1, (i % 2 == 0) ? RT : LW, i[0], 1, 4'd13, 1, C_ZERO, 1);
`else
    for (int i = 0; i < 11; i++)
      step(1, JAL, i[0], 1, 4'd13, 1, C_ZERO, 0);
    step(0, BAD, 0, 1, 4'd0, 0, C_ZERO,   0);
    step(1, BAD, 0, 1, 4'd0, 0, C_FRDY,   0);
    step(1, BAD, 0, 1, 4'd1, 0, C_DECODE, 0);
    for (int i = 0; i < 11; i++)
      step(1, (i % 2 == 0) ? RT : LW, i[0], 1, 4'd13, 1, C_ZERO, 0);
`endif
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
